// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, header tag and transmit FSM encoding for the
// frame-to-SPI readout path.
package fb_pkg;

    localparam int H_PIXELS    = 320;
    localparam int V_LINES     = 240;
    localparam int WORD_BITS   = 16;
    // 1 bpp frame packed into 16-bit words.
    localparam int FRAME_WORDS = (H_PIXELS * V_LINES) / WORD_BITS;

    localparam logic [7:0] HEADER_TAG = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_DONE   = 2'd3
    } tx_state_e;

    // Header word sent ahead of every frame: tag in the upper byte, frame
    // availability in bit 0.
    function automatic logic [15:0] header_word(input logic [7:0] tag, input logic ready);
        return {tag, 7'b0, ready};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input with single-cycle rise and
// fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next values: shift the input through the synchronizer and keep the
    // previous synchronized level for edge detection.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and history flops, reset to the idle level of the line.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so each flop samples the value from
        // before the edge; blocking here would collapse the chain.
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/frame_spi_tx.sv
// Streams a completed framebuffer to an MCU acting as SPI mode-0 master:
// a header word announcing frame availability, then FRAME_WORDS data words.
module frame_spi_tx #(
    parameter int          ADDR_WIDTH  = 13,
    parameter int          FRAME_WORDS = fb_pkg::FRAME_WORDS,
    parameter logic [7:0]  HEADER_TAG  = fb_pkg::HEADER_TAG
) (
    input  logic                  cam_pclk,
    input  logic                  rst,
    input  logic                  frame_ready,
    input  logic                  buf_sel,
    output logic                  frame_busy,
    output logic                  rd_buf,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [15:0]           rd_data,
    input  logic                  spi_sck,
    input  logic                  spi_ncs,
    output logic                  spi_miso
);

    import fb_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

    // Synchronized SPI lines.
    logic sck_lvl, sck_rise, sck_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk      (cam_pclk),
        .rst      (rst),
        .async_in (spi_sck),
        .sync_out (sck_lvl),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_ncs_sync (
        .clk      (cam_pclk),
        .rst      (rst),
        .async_in (spi_ncs),
        .sync_out (ncs_lvl),
        .rise     (ncs_rise),
        .fall     (ncs_fall)
    );

    // Mode 0 transmit only acts on SCK falling edges.
    logic unused_sck;
    assign unused_sck = sck_lvl ^ sck_rise;

    tx_state_e             state_q, state_d;
    logic                  ready_q, ready_d;        // a frame is waiting to be sent
    logic                  sel_q, sel_d;            // buffer holding that frame
    logic                  pend_q, pend_d;          // frame_ready seen during a transfer
    logic                  pend_sel_q, pend_sel_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_buf_q, rd_buf_d;
    logic [15:0]           shift_q, shift_d;
    logic [15:0]           hold_q, hold_d;         // prefetched next word
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;  // data word being shifted
    logic [1:0]            fetch_q, fetch_d;        // read latency pipeline
    logic [1:0]            flush_q, flush_d;        // synchronizer settle after reset
    logic                  armed_q, armed_d;        // ncs seen high since reset
    logic                  in_xfer;
    logic                  load_next;

    assign in_xfer = (state_q == ST_HEADER) || (state_q == ST_DATA);

    // Next-state logic: FSM, prefetch, frame hand-off from the writer.
    always_comb begin
        // NOTE: every _d defaults to its _q first so no branch leaves a
        // signal unassigned and no latch is inferred.
        state_d    = state_q;
        ready_d    = ready_q;
        sel_d      = sel_q;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        busy_d     = busy_q;
        rd_addr_d  = rd_addr_q;
        rd_buf_d   = rd_buf_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        fetch_d    = {fetch_q[0], 1'b0};
        flush_d    = {flush_q[0], 1'b1};
        // A low ncs held through reset must not look like a new selection.
        armed_d    = armed_q | (flush_q[1] & ncs_lvl);
        load_next  = 1'b0;

        // rd_data reflects the address two edges after rd_addr was updated.
        if (fetch_q[1]) begin
            hold_d = rd_data;
        end

        if (ncs_rise) begin
            // Deselect wins over any concurrent SCK edge; an unfinished
            // frame keeps ready set so it is sent again.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            if (pend_q) begin
                ready_d = 1'b1;
                sel_d   = pend_sel_q;
                pend_d  = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rd_addr_d  = '0;
                    rd_buf_d   = sel_q;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    if (ncs_fall && armed_q) begin
                        state_d    = ST_HEADER;
                        shift_d    = header_word(HEADER_TAG, ready_q);
                        busy_d     = ready_q;
                        fetch_d[0] = 1'b1;
                    end
                end
                ST_HEADER, ST_DATA: begin
                    if (sck_fall) begin
                        shift_d   = {shift_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            if (state_q == ST_HEADER) begin
                                if (ready_q) begin
                                    state_d   = ST_DATA;
                                    load_next = 1'b1;
                                end else begin
                                    state_d = ST_DONE;
                                end
                            end else if (word_cnt_q == LAST_ADDR) begin
                                ready_d = 1'b0;
                                busy_d  = 1'b0;
                                state_d = ST_DONE;
                            end else begin
                                word_cnt_d = word_cnt_q + 1'b1;
                                load_next  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // DONE: output stays low until deselect.
                end
            endcase
        end

        // Move the prefetched word into the shifter and fetch the next one;
        // the address saturates on the last word of the frame.
        if (load_next) begin
            shift_d    = hold_q;
            fetch_d[0] = 1'b1;
            if (rd_addr_q != LAST_ADDR) begin
                rd_addr_d = rd_addr_q + 1'b1;
            end
        end

        // A frame completed by the writer mid-transfer waits in the pending
        // slot; the newest one wins.
        if (frame_ready) begin
            if (in_xfer && (state_d != ST_IDLE)) begin
                pend_d     = 1'b1;
                pend_sel_d = buf_sel;
            end else begin
                ready_d = 1'b1;
                sel_d   = buf_sel;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            sel_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_sel_q <= 1'b0;
            busy_q     <= 1'b0;
            rd_addr_q  <= '0;
            rd_buf_q   <= 1'b0;
            shift_q    <= '0;
            hold_q     <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            fetch_q    <= '0;
            flush_q    <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            sel_q      <= sel_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            busy_q     <= busy_d;
            rd_addr_q  <= rd_addr_d;
            rd_buf_q   <= rd_buf_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            fetch_q    <= fetch_d;
            flush_q    <= flush_d;
            armed_q    <= armed_d;
        end
    end

    assign frame_busy = busy_q;
    assign rd_buf     = rd_buf_q;
    assign rd_addr    = rd_addr_q;
    assign spi_miso   = in_xfer & ~ncs_lvl & shift_q[15];

endmodule

// File: tb/tb_frame_spi_tx.sv
// Directed bench for frame_spi_tx with a 4-word frame and a 1-cycle-latency
// framebuffer returning 16'h1000 + address.
module tb_frame_spi_tx;

    localparam int FW = 4;
    localparam int AW = 13;

    logic          cam_pclk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_ready = 1'b0;
    logic          buf_sel = 1'b0;
    logic          spi_sck = 1'b0;
    logic          spi_ncs = 1'b1;
    logic          frame_busy;
    logic          rd_buf;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic          spi_miso;

    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] max_addr = '0;
    logic [127:0]  bits;
    int            busy_low;

    always #5 cam_pclk = ~cam_pclk;

    frame_spi_tx #(.ADDR_WIDTH(AW), .FRAME_WORDS(FW), .HEADER_TAG(8'hA5)) dut (
        .cam_pclk    (cam_pclk),
        .rst         (rst),
        .frame_ready (frame_ready),
        .buf_sel     (buf_sel),
        .frame_busy  (frame_busy),
        .rd_buf      (rd_buf),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .spi_sck     (spi_sck),
        .spi_ncs     (spi_ncs),
        .spi_miso    (spi_miso)
    );

    // Framebuffer model: registered read, out-of-range addresses poisoned.
    always @(posedge cam_pclk) begin
        rd_data <= (rd_addr < FW) ? (16'h1000 + 16'(rd_addr)) : 16'hDEAD;
        if (rd_addr > max_addr) max_addr <= rd_addr;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_frame(input logic sel);
        @(negedge cam_pclk);
        frame_ready = 1'b1;
        buf_sel     = sel;
        @(negedge cam_pclk);
        frame_ready = 1'b0;
    endtask

    // MCU side: mode 0, SCK = cam_pclk/8, random phase against cam_pclk.
    // Samples MISO just before each rising edge, MSB first.
    task automatic spi_read(input int nbits, output logic [127:0] rx, output int low_cnt);
        int ph;
        ph = int'($urandom_range(0, 8));
        @(posedge cam_pclk);
        #(1 + ph);
        spi_ncs = 1'b0;
        rx      = '0;
        low_cnt = 0;
        for (int i = 0; i < nbits; i++) begin
            #40;
            rx = {rx[126:0], spi_miso};
            if (frame_busy !== 1'b1) low_cnt++;
            spi_sck = 1'b1;
            #40;
            spi_sck = 1'b0;
        end
        #40;
        spi_ncs = 1'b1;
        #100;
    endtask

    // Checks an 80-bit read: header then words 0x1000..0x1003.
    task automatic check_frame(input string tag, input logic [127:0] rx, input logic [15:0] hdr);
        check({tag, "_hdr"}, rx[79:64], hdr);
        for (int i = 0; i < FW; i++) begin
            check($sformatf("%s_w%0d", tag, i), rx[63 - 16*i -: 16], 16'h1000 + 16'(i));
        end
    endtask

    initial begin
        // Reset state.
        repeat (4) @(negedge cam_pclk);
        check("rst_miso", spi_miso, 0);
        check("rst_busy", frame_busy, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_buf", rd_buf, 0);
        rst = 1'b0;
        repeat (5) @(negedge cam_pclk);

        // No frame available: header A500 then zeros, busy never rises.
        spi_read(32, bits, busy_low);
        check("t1_hdr", bits[31:16], 16'hA500);
        check("t1_tail", bits[15:0], 16'h0000);
        check("t1_busy_low_samples", busy_low, 32);
        check("t1_busy_after", frame_busy, 0);

        // Full frame from buffer 1, then header reports nothing pending.
        pulse_frame(1'b1);
        repeat (3) @(negedge cam_pclk);
        check("t2_rd_buf", rd_buf, 1);
        spi_read(80, bits, busy_low);
        check_frame("t2", bits, 16'hA501);
        check("t2_busy_low_samples", busy_low, 0);
        check("t2_busy_after", frame_busy, 0);
        spi_read(16, bits, busy_low);
        check("t2_second_hdr", bits[15:0], 16'hA500);

        // Abort after 24 data bits, then the same frame is resent whole.
        pulse_frame(1'b1);
        spi_read(40, bits, busy_low);
        check("t3_hdr", bits[39:24], 16'hA501);
        check("t3_w0", bits[23:8], 16'h1000);
        check("t3_w1_partial", bits[7:0], 8'h10);
        check("t3_busy_after_abort", frame_busy, 0);
        check("t3_rd_addr_idle", rd_addr, 0);
        spi_read(80, bits, busy_low);
        check_frame("t3_resend", bits, 16'hA501);

        // New frame in buffer 0 arrives mid-DATA of a buffer-1 frame.
        pulse_frame(1'b1);
        fork
            spi_read(80, bits, busy_low);
            begin
                #(36 * 80);
                @(negedge cam_pclk);
                frame_ready = 1'b1;
                buf_sel     = 1'b0;
                @(negedge cam_pclk);
                frame_ready = 1'b0;
                repeat (3) @(negedge cam_pclk);
                check("t4_rd_buf_during", rd_buf, 1);
            end
        join
        check_frame("t4_cur", bits, 16'hA501);
        check("t4_busy_low_samples", busy_low, 0);
        check("t4_rd_buf_next", rd_buf, 0);
        spi_read(80, bits, busy_low);
        check_frame("t4_next", bits, 16'hA501);
        spi_read(16, bits, busy_low);
        check("t4_drained_hdr", bits[15:0], 16'hA500);

        // Reset mid-DATA while the MCU keeps clocking with ncs low.
        pulse_frame(1'b1);
        fork
            spi_read(80, bits, busy_low);
            begin
                #(41 * 80);
                @(negedge cam_pclk);
                rst = 1'b1;
                @(negedge cam_pclk);
                check("t5_miso", spi_miso, 0);
                check("t5_busy", frame_busy, 0);
                check("t5_rd_addr", rd_addr, 0);
                rst = 1'b0;
            end
        join
        check("t5_hdr", bits[79:64], 16'hA501);
        check("t5_quiet_after_rst", bits[37:0], 0);
        check("t5_busy_after", frame_busy, 0);
        spi_read(16, bits, busy_low);
        check("t5_hdr_after_rst", bits[15:0], 16'hA500);

        // Many frames at full SCK rate with random phase.
        for (int f = 0; f < 100; f++) begin
            pulse_frame(1'(f));
            repeat (2) @(negedge cam_pclk);
            check($sformatf("t6_f%0d_rd_buf", f), rd_buf, 64'(f % 2));
            spi_read(80, bits, busy_low);
            check_frame($sformatf("t6_f%0d", f), bits, 16'hA501);
        end

        check("max_rd_addr", max_addr, FW - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
